// File: rtl/ppl_pkg.sv
// Shared display and pipeline constants for the scanner and the pipeline controller.
// Both blocks import this package so that they agree on the frame-end address.
package ppl_pkg;

  localparam int unsigned H_DISP       = 1280;
  localparam int unsigned V_DISP       = 720;
  localparam int unsigned PPL_DEPTH    = 6;
  localparam int unsigned FRAME_PIXELS = H_DISP * V_DISP;
  localparam int unsigned ADDR_W       = $clog2(FRAME_PIXELS);
  localparam int unsigned X_W          = $clog2(H_DISP);
  localparam int unsigned Y_W          = $clog2(V_DISP);

  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_CLEAR,
    UPD_NEXT_ROW,
    UPD_NEXT_COL
  } upd_e;

endpackage

// File: rtl/ppl_delay_line.sv
// Shift register with asynchronous reset that advances only while en is high.
// Its length matches the render pipeline depth.
module ppl_delay_line #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = din;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ppl_scanner.sv
// Raster scanner: issues (x, y, linear address) once per enabled advance and
// carries every advance slot through a pipeline-depth delay line.
module ppl_scanner #(
  parameter int unsigned H_DISP    = ppl_pkg::H_DISP,
  parameter int unsigned V_DISP    = ppl_pkg::V_DISP,
  parameter int unsigned PPL_DEPTH = ppl_pkg::PPL_DEPTH,
  parameter int unsigned ADDR_W    = ppl_pkg::ADDR_W,
  parameter int unsigned X_W       = ppl_pkg::X_W,
  parameter int unsigned Y_W       = ppl_pkg::Y_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv,
  input  logic              scanner_en,
  input  logic              restart,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic              frame_last,
  output logic [ADDR_W-1:0] pixel_addr_out,
  output logic              valid_out
);

  import ppl_pkg::*;

  localparam logic [X_W-1:0] X_LAST = X_W'(H_DISP - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_DISP - 1);

  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              iss;
  logic              x_last;
  logic [ADDR_W:0]   tail;
  upd_e              upd;

  assign iss        = scanner_en & adv;
  assign x_last     = (x_q == X_LAST);
  assign frame_last = x_last && (y_q == Y_LAST);

  // restart outranks the issue-driven update but never blocks the issue itself
  always_comb begin
    upd = UPD_HOLD;
    if (restart) begin
      upd = UPD_CLEAR;
    end else if (iss) begin
      if (frame_last)  upd = UPD_CLEAR;
      else if (x_last) upd = UPD_NEXT_ROW;
      else             upd = UPD_NEXT_COL;
    end
  end

  // linear address advances by one on every non-wrapping issue, so y*H_DISP+x holds without a multiplier
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    unique case (upd)
      UPD_CLEAR: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
      end
      UPD_NEXT_ROW: begin
        x_d    = '0;
        y_d    = y_q + Y_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
      UPD_NEXT_COL: begin
        x_d    = x_q + X_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      addr_q <= addr_d;
    end
  end

  ppl_delay_line #(
    .WIDTH (ADDR_W + 1),
    .DEPTH (PPL_DEPTH)
  ) u_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .din  ({addr_q, iss}),
    .dout (tail)
  );

  assign x              = x_q;
  assign y              = y_q;
  assign pixel_addr     = addr_q;
  assign pixel_addr_out = tail[ADDR_W:1];
  assign valid_out      = tail[0];

endmodule

// File: tb/tb_ppl_scanner.sv
// Randomised and directed bench for ppl_scanner on a reduced 40x16 display.
// The reference keeps a linear pixel index and a latency queue of advance slots.
module tb_ppl_scanner;

  localparam int unsigned H     = 40;
  localparam int unsigned V     = 16;
  localparam int unsigned FRAME = H * V;
  localparam int unsigned D     = 6;
  localparam int unsigned AW    = 10;
  localparam int unsigned XW    = 6;
  localparam int unsigned YW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          adv;
  logic          scanner_en;
  logic          restart;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [AW-1:0] pixel_addr;
  logic          frame_last;
  logic [AW-1:0] pixel_addr_out;
  logic          valid_out;

  always #5 clk = ~clk;

  ppl_scanner #(
    .H_DISP    (H),
    .V_DISP    (V),
    .PPL_DEPTH (D),
    .ADDR_W    (AW),
    .X_W       (XW),
    .Y_W       (YW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .adv            (adv),
    .scanner_en     (scanner_en),
    .restart        (restart),
    .x              (x),
    .y              (y),
    .pixel_addr     (pixel_addr),
    .frame_last     (frame_last),
    .pixel_addr_out (pixel_addr_out),
    .valid_out      (valid_out)
  );

  int          checks    = 0;
  int          errors    = 0;
  int          m_addr    = 0;
  int          shift_cnt = 0;
  int          seen_cnt  = 0;
  logic [AW:0] exp_q[$];
  logic [AW:0] cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Tail shows the slot pushed D-1 advances before the current one.
  task automatic reset_model();
    m_addr = 0;
    exp_q.delete();
    repeat (D - 1) exp_q.push_back('0);
    cur      = '0;
    seen_cnt = shift_cnt;
  endtask

  task automatic check_counters();
    check("x", 32'(x), m_addr % H);
    check("y", 32'(y), m_addr / H);
    check("pixel_addr", 32'(pixel_addr), m_addr);
    check("frame_last", 32'(frame_last), (m_addr == FRAME - 1) ? 1 : 0);
  endtask

  task automatic step(input logic en, input logic a, input logic rs);
    logic iss_m;
    scanner_en = en;
    adv        = a;
    restart    = rs;
    @(posedge clk);
    iss_m = en & a;
    if (!rst) begin
      if (a) begin
        exp_q.push_back({AW'(m_addr), iss_m});
        shift_cnt++;
      end
      if (rs)         m_addr = 0;
      else if (iss_m) m_addr = (m_addr + 1) % FRAME;
    end
    #1 check_counters();
  endtask

  // Monitor: consumes one expected slot per observed advance, checks the tail every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) continue;
      while (seen_cnt < shift_cnt) begin
        if (exp_q.size() != 0) cur = exp_q.pop_front();
        seen_cnt++;
      end
      check("valid_out", 32'(valid_out), 32'(cur[0]));
      check("pixel_addr_out", 32'(pixel_addr_out), 32'(cur[AW:1]));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  int          fl_cnt;
  logic [31:0] fl_addr;

  initial begin
    rst        = 1'b1;
    adv        = 1'b0;
    scanner_en = 1'b0;
    restart    = 1'b0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_counters();
    check("rst_tail_addr", 32'(pixel_addr_out), 0);
    check("rst_tail_valid", 32'(valid_out), 0);
    rst = 1'b0;

    // first issues and pipeline latency
    repeat (7) step(1'b1, 1'b1, 1'b0);

    // end of row 0 rolls into row 1
    while (m_addr != H - 1) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("row_wrap_x", 32'(x), 0);
    check("row_wrap_y", 32'(y), 1);
    check("row_wrap_addr", 32'(pixel_addr), H);

    // one complete frame from (0,0)
    step(1'b0, 1'b1, 1'b1);
    fl_cnt  = 0;
    fl_addr = '0;
    repeat (FRAME) begin
      if (frame_last) begin
        fl_cnt++;
        fl_addr = 32'(pixel_addr);
      end
      step(1'b1, 1'b1, 1'b0);
    end
    check("frame_last_count", 32'(fl_cnt), 1);
    check("frame_last_addr", fl_addr, FRAME - 1);
    check("frame_wrap_addr", 32'(pixel_addr), 0);
    repeat (D) step(1'b0, 1'b1, 1'b0);

    // bubble in the issue stream
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("bubble_addr", 32'(pixel_addr), 2);
    repeat (D) step(1'b0, 1'b1, 1'b0);

    // restart coincident with an issue at addr 500
    while (m_addr != 500) step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("restart_addr", 32'(pixel_addr), 0);
    repeat (D) step(1'b0, 1'b1, 1'b0);

    // random traffic with stalls and occasional restarts
    repeat (3000) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
    end

    // asynchronous reset mid-frame with the delay line full of valid pixels
    step(1'b0, 1'b1, 1'b1);
    while (m_addr != 300) step(1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_x", 32'(x), 0);
    check("arst_y", 32'(y), 0);
    check("arst_addr", 32'(pixel_addr), 0);
    check("arst_frame_last", 32'(frame_last), 0);
    check("arst_tail_addr", 32'(pixel_addr_out), 0);
    check("arst_tail_valid", 32'(valid_out), 0);
    reset_model();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (D + 2) step(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ppl_scanner.md
# ppl_scanner

Raster scanner for the render pipeline. Issues one screen coordinate (x, y, linear address) per enabled cycle and carries each issued address through a delay line matched to the pipeline depth. The delayed address is what the pipeline controller watches for end-of-frame. Sits directly upstream of the pipeline controller: it consumes `scanner_en`/`next_en` and produces `pixel_addr_out`.

## Interface
- `H_DISP`, default 1280: active pixels per line.
- `V_DISP`, default 720: active lines per frame.
- `PPL_DEPTH`, default 6: pipeline latency in advance cycles; delay-line length (≥1).
- `ADDR_W`, default 20: address width; must satisfy 2^ADDR_W ≥ H_DISP·V_DISP.
- `X_W`, default 11: x width; 2^X_W ≥ H_DISP.
- `Y_W`, default 10: y width; 2^Y_W ≥ V_DISP.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `adv`  in  1  pipeline advance (controller's `next_en`); delay line shifts only when high.
- `scanner_en`  in  1  issue current pixel this cycle; effective only with `adv`.
- `restart`  in  1  synchronous pulse; next issued pixel is (0,0).
- `x`  out  X_W  current column, registered.
- `y`  out  Y_W  current row, registered.
- `pixel_addr`  out  ADDR_W  y·H_DISP+x, registered.
- `frame_last`  out  1  combinational; high when (x,y) = (H_DISP-1, V_DISP-1).
- `pixel_addr_out`  out  ADDR_W  address at delay-line tail.
- `valid_out`  out  1  valid flag at delay-line tail.

## Operation
- Issue event: `iss = scanner_en & adv`. The pixel issued is the current registered (x, y, pixel_addr).
- Counter update, priority order:
  - `restart`: x, y, pixel_addr ← 0. Applies whether or not `iss` is high; if `iss` is also high, the current pixel is still issued.
  - `iss` and `frame_last`: x, y, pixel_addr ← 0 (wrap).
  - `iss` and x = H_DISP-1: x ← 0, y ← y+1, pixel_addr ← pixel_addr+1.
  - `iss` otherwise: x ← x+1, pixel_addr ← pixel_addr+1.
  - Else: hold.
- pixel_addr is maintained incrementally; no multiplier. Invariant: pixel_addr = y·H_DISP+x at all times.
- Delay line: PPL_DEPTH stages of {addr, valid}.
  - On `adv`, stage0 ← {pixel_addr, iss} and stage k ← stage k-1.
  - With `adv` low, all stages hold.
  - Bubbles (`adv` high, `iss` low) push the held address with valid=0.
- `pixel_addr_out`/`valid_out` = last stage.
- `restart` does not flush the delay line; in-flight pixels drain normally.
- `scanner_en` high with `adv` low: ignored; no issue, no shift.

## Timing
- Reset values: x=0, y=0, pixel_addr=0, frame_last=0 (follows counters), all stages {0,0}, so pixel_addr_out=0 and valid_out=0.
- Counter latency: 1 cycle from `iss` to the updated x/y/pixel_addr.
- Delay-line latency: a pixel issued on a cycle with `adv` appears at `pixel_addr_out` after exactly PPL_DEPTH `adv` cycles, counting the issue cycle's shift. With `adv` continuously high, that is PPL_DEPTH clocks after the issue edge.
- Wrap: a frame is exactly H_DISP·V_DISP issues. The issue after (H_DISP-1, V_DISP-1) is (0,0).
- Reset mid-frame: async clear of everything; first issue after deassertion is (0,0).
- No combinational path from inputs to outputs except `frame_last` (from registers only).

## Structure
- Shared package `ppl_pkg`:
  - display constants H_DISP/V_DISP;
  - PPL_DEPTH;
  - derived widths ADDR_W/X_W/Y_W;
  - FRAME_PIXELS = H_DISP·V_DISP.
- The controller uses the same package so that the frame-end constant matches.
- One sub-module: `ppl_delay_line` (parameters WIDTH, DEPTH; ports clk, rst, en, din, dout). Async-reset shift register instantiated once with WIDTH = ADDR_W+1.
- Counter logic stays in the top module.

## Test plan
- Reset, then `adv`=`scanner_en`=1 for 7 cycles, PPL_DEPTH=6 → x = 0,1,2,…; `valid_out` first high 6 cycles after first issue, with `pixel_addr_out`=0, then 1.
- Run to x = H_DISP-1 = 1279, y = 0, issue once → x=0, y=1, pixel_addr=1280.
- Run a full frame of 921600 issues → `frame_last` high exactly once, at addr 921599; the next cycle x=y=pixel_addr=0; the tail later shows 921599 then 0.
- `adv`=1 with `scanner_en` toggling 1,0,1 → counters step 0→1 hold →2; the tail shows addrs 0, 1(valid=0), 1(valid=1) in sequence.
- At addr 500, pulse `restart` with `iss`=1 → addr 500 enters the delay line and the next pixel_addr is 0; in-flight 495–499 still emerge valid.
- Assert `rst` mid-frame at addr 12345 with the delay line full → all outputs 0 immediately; after release, first issue is addr 0 and `valid_out` stays low for 6 cycles.
